alu_muldiv_sequencer: RTL

- Multi-cycle controller that executes RV32M multiply/divide ops by sequencing the shared 32-bit execute-stage ALU over 32 iterations.
- Sits beside the EX stage. While busy, it takes ownership of the ALU operand/control inputs via alu_sel and stalls the pipeline.
- Request and response sides each use a valid/ready handshake.

---
 rtl/alu_muldiv_sequencer_pkg.sv | 52 +++++
 rtl/alu_muldiv_sequencer_if.sv | 31 +++
 rtl/alu_muldiv_sequencer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_sequencer_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
//   muldiv_op_t    : funct3-ordered M-extension opcodes
//   muldiv_state_t : sequencer FSM states
//   ALU_ADD/SUB/SLTU: ALU control codes, shared with the EX-stage ALU decoder
// Helpers: is_mul() classifies an opcode; pick_result() selects the
// hi or lo half of the {hi,lo} datapath as the architectural result.
package muldiv_pkg;

    localparam int XLEN       = 32;
    localparam int ITER_CNT_W = 6;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MUL_ITER = 3'd1,
        ST_DIV_CMP  = 3'd2,
        ST_DIV_SUB  = 3'd3,
        ST_NEG_IN   = 3'd4,
        ST_NEG_OUT  = 3'd5,
        ST_DONE     = 3'd6
    } muldiv_state_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    function automatic logic is_mul(input muldiv_op_t op);
        return op inside {MUL, MULH, MULHSU, MULHU};
    endfunction

    // Multiply: {hi,lo} is the 64-bit product. Divide: lo is the quotient,
    // hi is the remainder.
    function automatic logic [XLEN-1:0] pick_result(input muldiv_op_t op,
                                                    input logic [XLEN-1:0] hi,
                                                    input logic [XLEN-1:0] lo);
        case (op)
            MUL, DIV, DIVU: return lo;
            default:        return hi;
        endcase
    endfunction

endpackage

// File: rtl/alu_muldiv_sequencer_if.sv
// Request/response bus of the multiply/divide sequencer.
//   req_valid/req_ready/req_op/req_a/req_b : request channel
//   resp_valid/resp_ready/resp_data        : response channel
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// Once valid is raised it stays high, with its payload stable, until that
// transfer; ready may change freely and is never allowed to depend on a
// transfer completing in the same cycle.
// master drives requests and consumes responses; slave is the sequencer.
interface alu_muldiv_sequencer_if;
    import muldiv_pkg::*;

    logic             req_valid;
    logic             req_ready;
    muldiv_op_t       req_op;
    logic [XLEN-1:0]  req_a;
    logic [XLEN-1:0]  req_b;
    logic             resp_valid;
    logic             resp_ready;
    logic [XLEN-1:0]  resp_data;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_data
    );

endinterface

// File: rtl/alu_muldiv_sequencer.sv
// RV32M multiply/divide sequencer that borrows the shared EX-stage ALU.
// Multiply is 32 shift-add steps; unsigned divide is restoring division,
// one compare cycle and one subtract cycle per quotient bit.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   flush         : abort the in-flight op, no response
//   bus (slave)   : request/response handshake channels
//   busy          : high outside IDLE, stalls the pipeline
//   alu_sel       : 1 while alu_a/alu_b/alu_ctrl must drive the ALU
//   alu_a/b/ctrl  : ALU operands and opcode
//   alu_result    : combinational ALU result of the same cycle
//   state_dbg     : current FSM state
// Build option: define MULDIV_SIGNED_EN for MULH/MULHSU/DIV/REM support;
// without it those opcodes complete after one cycle with a zero result.
module alu_muldiv_sequencer
    import muldiv_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    alu_muldiv_sequencer_if.slave  bus,
    output logic                   busy,
    output logic                   alu_sel,
    output logic [XLEN-1:0]        alu_a,
    output logic [XLEN-1:0]        alu_b,
    output logic [3:0]             alu_ctrl,
    input  logic [XLEN-1:0]        alu_result,
    output muldiv_state_t          state_dbg
);

    muldiv_state_t         state_q, state_d;
    muldiv_op_t            op_q, op_d;
    // hi: upper product / partial remainder. lo: multiplier being shifted
    // out / dividend shifting out while quotient bits shift in.
    logic [XLEN-1:0]       hi_q, hi_d;
    logic [XLEN-1:0]       lo_q, lo_d;
    logic [XLEN-1:0]       b_q, b_d;          // multiplicand or divisor
    logic [ITER_CNT_W-1:0] iter_q, iter_d;
    logic                  lt_q, lt_d;        // shifted remainder < divisor
    logic                  neg_a_q, neg_a_d;  // operand a still needs abs()
    logic                  neg_b_q, neg_b_d;  // operand b still needs abs()
    logic                  neg_res_q, neg_res_d;
    logic [XLEN-1:0]       result_q, result_d;

    logic [XLEN-1:0]       rem_sh;
    logic [XLEN-1:0]       sum;
    logic                  carry;
    muldiv_state_t         work_state;
    muldiv_state_t         finish_state;

`ifdef MULDIV_SIGNED_EN
    logic req_a_neg;
    logic req_b_neg;
    logic req_is_signed_div;
    assign req_a_neg         = bus.req_a[XLEN-1];
    assign req_b_neg         = bus.req_b[XLEN-1] && (bus.req_op != MULHSU);
    assign req_is_signed_div = (bus.req_op == DIV) || (bus.req_op == REM);
`endif

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = (state_q == ST_DONE);
    assign bus.resp_data  = result_q;
    assign busy           = (state_q != ST_IDLE);
    assign state_dbg      = state_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        b_d       = b_q;
        iter_d    = iter_q;
        lt_d      = lt_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        neg_res_d = neg_res_q;
        result_d  = result_q;
        alu_sel   = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_ctrl  = ALU_ADD;
        rem_sh    = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
        sum       = hi_q;
        carry     = 1'b0;
        work_state   = is_mul(op_q) ? ST_MUL_ITER : ST_DIV_CMP;
        finish_state = neg_res_q ? ST_NEG_OUT : ST_DONE;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && !flush) begin
                    op_d      = bus.req_op;
                    hi_d      = '0;
                    lo_d      = bus.req_a;
                    b_d       = bus.req_b;
                    iter_d    = '0;
                    lt_d      = 1'b0;
                    neg_a_d   = 1'b0;
                    neg_b_d   = 1'b0;
                    neg_res_d = 1'b0;
                    case (bus.req_op)
                        MUL, MULHU: state_d = ST_MUL_ITER;
                        DIVU, REMU: begin
                            if (bus.req_b == '0) begin
                                state_d  = ST_DONE;
                                result_d = (bus.req_op == DIVU) ? {XLEN{1'b1}} : bus.req_a;
                            end else begin
                                state_d = ST_DIV_CMP;
                            end
                        end
                        default: begin
`ifdef MULDIV_SIGNED_EN
                            if (req_is_signed_div && bus.req_b == '0) begin
                                state_d  = ST_DONE;
                                result_d = (bus.req_op == DIV) ? {XLEN{1'b1}} : bus.req_a;
                            end else if (req_is_signed_div && bus.req_a == 32'h8000_0000
                                         && bus.req_b == {XLEN{1'b1}}) begin
                                // Overflow case: quotient wraps, remainder is zero.
                                state_d  = ST_DONE;
                                result_d = (bus.req_op == DIV) ? 32'h8000_0000 : '0;
                            end else begin
                                neg_a_d   = req_a_neg;
                                neg_b_d   = req_b_neg;
                                // Remainder takes the dividend's sign only.
                                neg_res_d = (bus.req_op == REM) ? req_a_neg
                                                                : (req_a_neg ^ req_b_neg);
                                if (req_a_neg || req_b_neg)
                                    state_d = ST_NEG_IN;
                                else
                                    state_d = is_mul(bus.req_op) ? ST_MUL_ITER : ST_DIV_CMP;
                            end
`else
                            state_d  = ST_DONE;
                            result_d = '0;
`endif
                        end
                    endcase
                end
            end

            ST_NEG_IN: begin
                // 0 - x, one negative operand per cycle, a first.
                alu_sel  = 1'b1;
                alu_ctrl = ALU_SUB;
                if (neg_a_q) begin
                    alu_b   = lo_q;
                    lo_d    = alu_result;
                    neg_a_d = 1'b0;
                    state_d = neg_b_q ? ST_NEG_IN : work_state;
                end else begin
                    alu_b   = b_q;
                    b_d     = alu_result;
                    neg_b_d = 1'b0;
                    state_d = work_state;
                end
            end

            ST_MUL_ITER: begin
                alu_sel  = 1'b1;
                alu_ctrl = ALU_ADD;
                alu_a    = hi_q;
                alu_b    = b_q;
                if (lo_q[0]) begin
                    sum   = alu_result;
                    carry = (alu_result < hi_q);  // wrap-around means carry out
                end
                hi_d   = {carry, sum[XLEN-1:1]};
                lo_d   = {sum[0], lo_q[XLEN-1:1]};
                iter_d = iter_q + 1'b1;
                if (iter_q == ITER_CNT_W'(XLEN - 1)) begin
                    state_d  = finish_state;
                    result_d = pick_result(op_q, hi_d, lo_d);
                end
            end

            ST_DIV_CMP: begin
                // The shifted remainder is 33 bits wide; when its top bit
                // (old rem msb) is set it is certainly >= the divisor.
                alu_sel  = 1'b1;
                alu_ctrl = ALU_SLTU;
                alu_a    = rem_sh;
                alu_b    = b_q;
                lt_d     = alu_result[0] & ~hi_q[XLEN-1];
                hi_d     = rem_sh;
                lo_d     = {lo_q[XLEN-2:0], 1'b0};
                state_d  = ST_DIV_SUB;
            end

            ST_DIV_SUB: begin
                // hi holds the shifted remainder; a 32-bit subtract is exact
                // because the true difference is below the divisor.
                alu_sel  = 1'b1;
                alu_ctrl = ALU_SUB;
                alu_a    = hi_q;
                alu_b    = b_q;
                if (!lt_q) begin
                    hi_d    = alu_result;
                    lo_d[0] = 1'b1;
                end
                iter_d = iter_q + 1'b1;
                if (iter_q == ITER_CNT_W'(XLEN - 1)) begin
                    state_d  = finish_state;
                    result_d = pick_result(op_q, hi_d, lo_d);
                end else begin
                    state_d = ST_DIV_CMP;
                end
            end

            ST_NEG_OUT: begin
                alu_sel = 1'b1;
                if (is_mul(op_q)) begin
                    // High word of -{hi,lo}: ~hi plus the carry out of ~lo + 1.
                    alu_ctrl = ALU_ADD;
                    alu_a    = ~hi_q;
                    alu_b    = {{(XLEN-1){1'b0}}, (lo_q == '0)};
                end else begin
                    alu_ctrl = ALU_SUB;
                    alu_b    = (op_q == DIV) ? lo_q : hi_q;
                end
                result_d = alu_result;
                state_d  = ST_DONE;
            end

            ST_DONE: begin
                if (bus.resp_ready)
                    state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase

        if (flush)
            state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= MUL;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            iter_q    <= '0;
            lt_q      <= 1'b0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            neg_res_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            b_q       <= b_d;
            iter_q    <= iter_d;
            lt_q      <= lt_d;
            neg_a_q   <= neg_a_d;
            neg_b_q   <= neg_b_d;
            neg_res_q <= neg_res_d;
            result_q  <= result_d;
        end
    end

endmodule
